// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP add/sub arbiter slice.
// Pipeline entries carry a fixed-width tag wide enough for the largest legal requester count.
package fp_arb_pkg;

  localparam int   FP_W     = 32;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
  localparam int   STAT_W   = 16;
  localparam int   ID_MAX_W = 4;

  typedef struct packed {
    logic [FP_W-1:0]     a;
    logic [FP_W-1:0]     b;
    logic                op;
    logic [ID_MAX_W-1:0] id;
  } pipeEntryT;

endpackage

// File: rtl/FPAddSub.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Handles zeros, subnormals, infinities and NaN (canonical quiet NaN out).
module FPAddSub
  import fp_arb_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        OpMode,
  output logic [31:0] Z
);

  logic        signB, effSub, swap, signL, resSign, roundUp;
  logic        nanA, nanB, infA, infB;
  logic [30:0] magL, magS, packedRes, rounded;
  logic [9:0]  eL, eS, diff, eNorm, shiftAmt;
  logic [23:0] mL, mS;
  logic [49:0] wide;
  logic [26:0] aligned, normd;
  logic [27:0] sum;
  logic [4:0]  lz;

  // NOTE: every variable gets a value at the top of the block so no path can infer a latch.
  always_comb begin
    signB    = B[31] ^ (OpMode == OP_SUB);
    nanA     = (A[30:23] == 8'hFF) && (A[22:0] != '0);
    nanB     = (B[30:23] == 8'hFF) && (B[22:0] != '0);
    infA     = (A[30:23] == 8'hFF) && (A[22:0] == '0);
    infB     = (B[30:23] == 8'hFF) && (B[22:0] == '0);
    effSub   = A[31] ^ signB;
    swap     = B[30:0] > A[30:0];
    signL    = swap ? signB : A[31];
    magL     = swap ? B[30:0] : A[30:0];
    magS     = swap ? A[30:0] : B[30:0];
    shiftAmt = '0;

    // Subnormals use an effective exponent of 1 and no hidden bit.
    eL   = (magL[30:23] == '0) ? 10'd1 : {2'b00, magL[30:23]};
    eS   = (magS[30:23] == '0) ? 10'd1 : {2'b00, magS[30:23]};
    mL   = {magL[30:23] != '0, magL[22:0]};
    mS   = {magS[30:23] != '0, magS[22:0]};
    diff = eL - eS;

    // Align the smaller operand keeping guard, round and a sticky OR of everything below.
    wide    = {mS, 26'd0} >> diff;
    aligned = (diff >= 10'd26) ? {26'd0, |mS} : {wide[49:24], |wide[23:0]};
    sum     = effSub ? ({1'b0, mL, 3'b000} - {1'b0, aligned})
                     : ({1'b0, mL, 3'b000} + {1'b0, aligned});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      normd = {sum[27:2], sum[1] | sum[0]};
      eNorm = eL + 10'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results land as subnormals.
      shiftAmt = ({5'd0, lz} < (eL - 10'd1)) ? {5'd0, lz} : (eL - 10'd1);
      normd    = sum[26:0] << shiftAmt;
      eNorm    = eL - shiftAmt;
    end

    // Rounding carry ripples into the exponent, covering subnormal->normal and overflow to inf.
    roundUp   = normd[2] & (normd[1] | normd[0] | normd[3]);
    packedRes = {normd[26] ? eNorm[7:0] : 8'd0, normd[25:3]};
    rounded   = packedRes + 31'(roundUp);
    resSign   = (sum == '0) ? (A[31] & signB) : signL;

    if (nanA || nanB || (infA && infB && effSub)) Z = 32'h7FC0_0000;
    else if (infA)                                Z = A;
    else if (infB)                                Z = {signB, B[30:0]};
    else if (eNorm >= 10'd255)                    Z = {resSign, 8'hFF, 23'd0};
    else                                          Z = {resSign, rounded};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves past the granted requester only when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] pointer, grantIdx, idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(pointer) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer <= '0;
    end else if (advance) begin
      pointer <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one FPAddSub between NUM_REQ requesters: round-robin grant, 2-stage pipeline, tagged response.
// Define FP_ARB_STATS_EN to add per-requester saturating grant counters (stat_clr / grant_cnt).
module fp_addsub_arbiter
  import fp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_z,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
`ifdef FP_ARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  logic               stall, accept, s1Valid;
  logic [NUM_REQ-1:0] grant, acceptVec;
  pipeEntryT          selEntry, s1Entry;
  logic [FP_W-1:0]    zComb;
  logic               unusedIdBits;

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = grant & {NUM_REQ{~stall & rst_n}};
  assign acceptVec = req_valid & req_ready;
  assign accept    = |acceptVec;
  assign busy      = s1Valid | rsp_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    selEntry = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        selEntry.a  = req_a[FP_W*i +: FP_W];
        selEntry.b  = req_b[FP_W*i +: FP_W];
        selEntry.op = req_op[i];
        selEntry.id = ID_MAX_W'(i);
      end
    end
  end

  // NOTE: payload registers are reset too, so rsp_z/rsp_id read 0 out of reset and never carry X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1Entry   <= '0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
    end else if (!stall) begin
      s1Valid   <= accept;
      s1Entry   <= selEntry;
      rsp_valid <= s1Valid;
      rsp_z     <= zComb;
      rsp_id    <= s1Entry.id[ID_W-1:0];
    end
  end

  // Tag bits above ID_W are always zero for this NUM_REQ.
  assign unusedIdBits = ^s1Entry.id;

  FPAddSub uFp (
    .A      (s1Entry.a),
    .B      (s1Entry.b),
    .OpMode (s1Entry.op),
    .Z      (zComb)
  );

`ifdef FP_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] grantCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantCnt <= '0;
    end else if (stat_clr) begin
      grantCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acceptVec[i] && (grantCnt[i] != '1)) grantCnt[i] <= grantCnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = grantCnt;
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter: directed FP vectors, round-robin order,
// backpressure, mid-flight reset and (with FP_ARB_STATS_EN) grant counters.
module tb_fp_addsub_arbiter;
  import fp_arb_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_op;
  logic [N*32-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready, busy;
  logic [31:0]     rsp_z;
  logic [1:0]      rsp_id;
`ifdef FP_ARB_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] grant_cnt;
`endif

  fp_addsub_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef FP_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] z;
  } vecT;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] z;
  } expT;

  int          total = 0;
  int          bad   = 0;
  expT         sbQ[$];
  logic [31:0] curZ[N];
  vecT         vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setReq(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] z);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_op[idx]         = op;
    curZ[idx]           = z;
  endtask

  // Called just after a falling edge: settle, optionally check the grant, score, advance one cycle.
  task automatic step(input string name, input logic doGrant, input logic [N-1:0] expGrant);
    logic [N-1:0] acc;
    expT          e;
    #1;
    if (doGrant) check(name, 32'(req_ready), 32'(expGrant));
    acc = req_valid & req_ready;
    if (rsp_valid && rsp_ready) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected_rsp: got id=%0d z=%h expected no response", name, rsp_id, rsp_z);
      end else begin
        e = sbQ.pop_front();
        check({name, "_rsp_id"}, 32'(rsp_id), 32'(e.id));
        check({name, "_rsp_z"}, rsp_z, e.z);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) sbQ.push_back('{id: 2'(i), z: curZ[i]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000};
    vecs[1]  = '{2, 32'h3FC00000, 32'h3F800000, OP_SUB, 32'h3F000000};
    vecs[2]  = '{2, 32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000};
    vecs[3]  = '{1, 32'h40000000, 32'h40400000, OP_ADD, 32'h40A00000};
    vecs[4]  = '{3, 32'h3F800000, 32'hBF800000, OP_ADD, 32'h00000000};
    vecs[5]  = '{1, 32'h3F800000, 32'h40000000, OP_SUB, 32'hBF800000};
    vecs[6]  = '{0, 32'h3F000000, 32'h3E800000, OP_ADD, 32'h3F400000};
    vecs[7]  = '{3, 32'h41200000, 32'h40800000, OP_SUB, 32'h40C00000};
    vecs[8]  = '{0, 32'h3F800000, 32'h33800000, OP_ADD, 32'h3F800000};
    vecs[9]  = '{1, 32'h3F800000, 32'h34400000, OP_ADD, 32'h3F800002};
    vecs[10] = '{2, 32'h7F800000, 32'h3F800000, OP_ADD, 32'h7F800000};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) curZ[i] = '0;
`ifdef FP_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset state, with every requester asking.
    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_z", rsp_z, 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, checking two-stage latency.
    for (int v = 0; v < 11; v++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[vecs[v].idx] = 1'b1;
      setReq(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].z);
      req_valid = oh;
      #1;
      check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(oh));
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      #1;
      check($sformatf("v%0d_stage1_rsp_valid", v), 32'(rsp_valid), 32'h0);
      check($sformatf("v%0d_stage1_busy", v), 32'(busy), 32'h1);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("v%0d_rsp_z", v), rsp_z, vecs[v].z);
      check($sformatf("v%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].idx));
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'h0);
      @(negedge clk);
    end

    // Fresh reset so the round-robin pointer starts at 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin: all four asking for 8 cycles -> grants 0,1,2,3,0,1,2,3.
    setReq(0, 32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000);
    setReq(1, 32'h40000000, 32'h3F800000, OP_ADD, 32'h40400000);
    setReq(2, 32'h40400000, 32'h3F800000, OP_ADD, 32'h40800000);
    setReq(3, 32'h40800000, 32'h3F800000, OP_ADD, 32'h40A00000);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[c % N] = 1'b1;
      if (c >= 2) begin
        #1;
        check($sformatf("rr_b2b_valid_c%0d", c), 32'(rsp_valid), 32'h1);
      end
      step($sformatf("rr_c%0d", c), 1'b1, oh);
    end
    req_valid = '0;
    for (int c = 0; c < 3; c++) step("rr_drain", 1'b0, '0);
    check("rr_all_drained", 32'(sbQ.size()), 32'h0);

    // Backpressure: fill both stages, hold rsp_ready low for 5 cycles.
    rsp_ready = 1'b0;
    req_valid = '1;
    step("bp_fill0", 1'b1, 4'b0001);
    step("bp_fill1", 1'b1, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'h0);
      check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
      check($sformatf("bp_z_c%0d", c), rsp_z, 32'h40000000);
      check($sformatf("bp_id_c%0d", c), 32'(rsp_id), 32'h0);
      step("bp_hold", 1'b0, '0);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) step("bp_drain", 1'b0, '0);
    check("bp_all_drained", 32'(sbQ.size()), 32'h0);

    // Mid-flight reset: accept from req 2 (pointer -> 3), then reset one cycle later.
    setReq(2, 32'h40400000, 32'h40400000, OP_ADD, 32'h40C00000);
    req_valid = 4'b0100;
    step("mr_accept", 1'b1, 4'b0100);
    req_valid = 4'b0010;
    rst_n     = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_req_ready", 32'(req_ready), 32'h0);
    sbQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer back at 0: req 1 wins over req 3.
    req_valid = 4'b1010;
    step("mr_ptr", 1'b1, 4'b0010);
    req_valid = '0;
    for (int c = 0; c < 4; c++) step("mr_after", 1'b0, '0);
    check("mr_drained", 32'(sbQ.size()), 32'h0);

`ifdef FP_ARB_STATS_EN
    stat_clr = 1'b1;
    step("st_clr0", 1'b0, '0);
    stat_clr = 1'b0;
    #1;
    check("st_cnt1_zero", 32'(grant_cnt[31:16]), 32'h0);
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) step("st_grant", 1'b1, 4'b0010);
    req_valid = '0;
    #1;
    check("st_cnt1_six", 32'(grant_cnt[31:16]), 32'd6);
    check("st_cnt0_zero", 32'(grant_cnt[15:0]), 32'h0);
    req_valid = 4'b0010;
    stat_clr  = 1'b1;
    step("st_clr_grant", 1'b1, 4'b0010);
    req_valid = '0;
    stat_clr  = 1'b0;
    #1;
    check("st_cnt1_cleared", 32'(grant_cnt[31:16]), 32'h0);
    for (int c = 0; c < 3; c++) step("st_drain", 1'b0, '0);
    check("st_drained", 32'(sbQ.size()), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
